// File: rtl/instruction_fetch_controller.sv
// Fetch stage: reads a word from instruction memory, stamps the PC into it and hands it to the
// decoder with a start/busy/done handshake, looping on the decoder's next PC until HALT or timeout.
`timescale 1ns/1ps
module instruction_fetch_controller #(
    parameter logic [4:0]  HALT_OPCODE    = 5'd31,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [4:0]  boot_pc,
    output logic        imem_req,
    output logic [4:0]  imem_addr,
    input  logic        imem_ready,
    input  logic [58:0] imem_rdata,
    output logic        start,
    output logic [58:0] instruction,
    input  logic        decode_busy,
    input  logic        decode_done,
    input  logic        fetch_stage_enable,
    input  logic [4:0]  next_pc_from_decode,
    output logic [4:0]  pc,
    output logic        halted,
    output logic        error,
    output logic [15:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_MEM, S_DISPATCH, S_WAIT_DONE, S_HALTED, S_ERROR
    } state_t;

    state_t      state, state_d;
    logic [15:0] wdog, wdog_d;
    logic [4:0]  pc_d, imem_addr_d;
    logic        imem_req_d, start_d, halted_d, error_d;
    logic [58:0] instruction_d;
    logic [15:0] fetch_count_d;
    logic [16:0] wdog_inc;
    logic        timeout;
    logic        unused_rdata_pc_field;

    // The memory's own [36:32] field is overwritten by the stamped PC.
    assign unused_rdata_pc_field = ^imem_rdata[36:32];

    assign wdog_inc = {1'b0, wdog} + 17'd1;
    assign timeout  = (TIMEOUT_CYCLES != 16'd0) && (wdog_inc == {1'b0, TIMEOUT_CYCLES});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            wdog        <= '0;
            pc          <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            start       <= 1'b0;
            instruction <= '0;
            halted      <= 1'b0;
            error       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_d;
            wdog        <= wdog_d;
            pc          <= pc_d;
            imem_req    <= imem_req_d;
            imem_addr   <= imem_addr_d;
            start       <= start_d;
            instruction <= instruction_d;
            halted      <= halted_d;
            error       <= error_d;
            fetch_count <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state;
        wdog_d        = wdog;
        pc_d          = pc;
        imem_req_d    = imem_req;
        imem_addr_d   = imem_addr;
        start_d       = start;
        instruction_d = instruction;
        halted_d      = halted;
        error_d       = error;
        fetch_count_d = fetch_count;

        case (state)
            S_IDLE: begin
                if (run) begin
                    pc_d        = boot_pc;
                    imem_req_d  = 1'b1;
                    imem_addr_d = boot_pc;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                imem_req_d = 1'b0;
                state_d    = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (imem_ready) begin
                    if (imem_rdata[56:52] == HALT_OPCODE) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        instruction_d = {imem_rdata[58:37], pc, imem_rdata[31:0]};
                        start_d       = 1'b1;
                        state_d       = S_DISPATCH;
                    end
                end else if (timeout) begin
                    start_d = 1'b0;
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    wdog_d = wdog_inc[15:0];
                end
            end
            S_DISPATCH: begin
                if (decode_busy) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (timeout) begin
                    start_d = 1'b0;
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    wdog_d = wdog_inc[15:0];
                end
            end
            S_WAIT_DONE: begin
                // Busy must be low so a done left over from the previous word is never taken.
                if (decode_done && fetch_stage_enable && !decode_busy) begin
                    pc_d          = next_pc_from_decode;
                    fetch_count_d = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;
                    if (run) begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = next_pc_from_decode;
                        state_d     = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (timeout) begin
                    start_d = 1'b0;
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    wdog_d = wdog_inc[15:0];
                end
            end
            S_HALTED: begin
                if (!run) begin
                    halted_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state) begin
            wdog_d = '0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench for instruction_fetch_controller: memory and decoder responders with random
// latencies, checked against a transaction-level model of PC, dispatched word and completion count.
`timescale 1ns/1ps
module tb_instruction_fetch_controller;

    logic        clk = 1'b0;
    logic        rst, run, imem_ready, decode_busy, decode_done, fetch_stage_enable;
    logic [4:0]  boot_pc, next_pc_from_decode;
    logic [58:0] imem_rdata;
    logic        imem_req, start, halted, error;
    logic [4:0]  imem_addr, pc;
    logic [58:0] instruction;
    logic [15:0] fetch_count;

    int checks = 0;
    int failures = 0;

    logic [58:0] mem [32];
    logic [4:0]  m_pc;
    logic [15:0] m_count;

    logic        x_found, x_req_one, x_start_early, x_start, x_start_after, x_req_next;
    logic [4:0]  x_addr, x_pc, x_addr_next;
    logic [58:0] x_word, x_instr, x_instr_hold;
    logic [15:0] x_count;
    int          x_start_cycles;

    instruction_fetch_controller #(.HALT_OPCODE(5'd31), .TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .rst(rst), .run(run), .boot_pc(boot_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .start(start), .instruction(instruction),
        .decode_busy(decode_busy), .decode_done(decode_done),
        .fetch_stage_enable(fetch_stage_enable), .next_pc_from_decode(next_pc_from_decode),
        .pc(pc), .halted(halted), .error(error), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [58:0] rand_word(input logic [4:0] op);
        logic [63:0] r;
        logic [58:0] w;
        r = {$urandom(), $urandom()};
        w = r[58:0];
        w[56:52] = op;
        return w;
    endfunction

    // What the decoder should receive: memory word with the fetch address in bits [36:32].
    function automatic logic [58:0] expect_word(input logic [58:0] w, input logic [4:0] p);
        return {w[58:37], p, w[31:0]};
    endfunction

    // One full fetch/dispatch/complete transaction with the given latencies; records observations.
    task automatic xact(input int mlat, input int blat, input int dlat, input logic [4:0] npc,
                        input bit stray, input bit drop_run);
        int n;
        bit stale;
        n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        x_found = imem_req;
        x_addr  = imem_addr;
        x_word  = mem[imem_addr];
        tick();
        x_req_one = !imem_req;
        x_start_early = 1'b0;
        for (int i = 1; i < mlat; i++) begin
            if (start) x_start_early = 1'b1;
            tick();
        end
        if (start) x_start_early = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = x_word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = rand_word(5'($urandom()));
        x_start = start;
        x_instr = instruction;
        stale = 1'($urandom_range(0, 1));
        decode_done = stale;
        fetch_stage_enable = stale;
        x_start_cycles = 0;
        for (int i = 0; i < blat; i++) begin
            if (start) x_start_cycles++;
            if (stray && i == 0) begin
                imem_ready = 1'b1;
                imem_rdata = rand_word(5'd31);
            end
            tick();
            imem_ready = 1'b0;
        end
        if (start) x_start_cycles++;
        decode_busy = 1'b1;
        decode_done = 1'b0;
        fetch_stage_enable = 1'b0;
        tick();
        x_start_after = start;
        x_instr_hold  = instruction;
        for (int i = 0; i < dlat; i++) tick();
        if (drop_run) run = 1'b0;
        decode_busy = 1'b0;
        decode_done = 1'b1;
        fetch_stage_enable = 1'b1;
        next_pc_from_decode = npc;
        tick();
        decode_done = 1'b0;
        fetch_stage_enable = 1'b0;
        next_pc_from_decode = 5'($urandom());
        x_pc = pc;
        x_count = fetch_count;
        x_req_next = imem_req;
        x_addr_next = imem_addr;
    endtask

    // Fetch phase only: answers the pending request after mlat cycles, leaves the decoder idle.
    task automatic fetch_only(input int mlat);
        int n;
        logic [4:0] a;
        n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        a = imem_addr;
        tick();
        for (int i = 1; i < mlat; i++) tick();
        imem_ready = 1'b1;
        imem_rdata = mem[a];
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b0; boot_pc = '0; imem_ready = 1'b0; imem_rdata = '0;
        decode_busy = 1'b0; decode_done = 1'b0; fetch_stage_enable = 1'b0; next_pc_from_decode = '0;
        tick(); tick();
        checks++; if (pc !== 5'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if (instruction !== 59'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instruction); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%b exp=0", imem_req); end
        m_count = '0;
    endtask

    task automatic test_basic();
        mem[3] = rand_word(5'd1);
        boot_pc = 5'd3;
        run = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL basic_req got=%b exp=1", imem_req); end
        checks++; if (pc !== 5'd3) begin failures++; $display("FAIL basic_boot_pc got=%0d exp=3", pc); end
        m_pc = 5'd3;
        xact(1, 1, 1, 5'd4, 1'b0, 1'b0);
        checks++; if (x_addr !== 5'd3) begin failures++; $display("FAIL basic_addr got=%0d exp=3", x_addr); end
        checks++; if (x_req_one !== 1'b1) begin failures++; $display("FAIL basic_req_one_cycle got=%b exp=1", x_req_one); end
        checks++; if (x_instr[36:32] !== 5'd3) begin failures++; $display("FAIL basic_stamp got=%0d exp=3", x_instr[36:32]); end
        checks++; if (x_instr !== expect_word(mem[3], 5'd3)) begin failures++; $display("FAIL basic_instr got=%h exp=%h", x_instr, expect_word(mem[3], 5'd3)); end
        checks++; if (x_start_cycles !== 2) begin failures++; $display("FAIL basic_start_len got=%0d exp=2", x_start_cycles); end
        checks++; if (x_start_after !== 1'b0) begin failures++; $display("FAIL basic_start_drop got=%b exp=0", x_start_after); end
        checks++; if (x_count !== 16'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", x_count); end
        checks++; if (x_req_next !== 1'b1 || x_addr_next !== 5'd4) begin failures++; $display("FAIL basic_next got=%b/%0d exp=1/4", x_req_next, x_addr_next); end
        m_pc = 5'd4;
        m_count = 16'd1;
    endtask

    task automatic test_latency();
        logic [4:0] npc;
        npc = 5'($urandom_range(8, 30));
        xact(5, 2, 1, npc, 1'b1, 1'b0);
        checks++; if (x_start_early !== 1'b0) begin failures++; $display("FAIL lat_start_early got=%b exp=0", x_start_early); end
        checks++; if (x_start !== 1'b1) begin failures++; $display("FAIL lat_start_rise got=%b exp=1", x_start); end
        checks++; if (x_instr !== expect_word(x_word, m_pc)) begin failures++; $display("FAIL lat_instr got=%h exp=%h", x_instr, expect_word(x_word, m_pc)); end
        checks++; if (x_instr_hold !== x_instr) begin failures++; $display("FAIL lat_stray_ready got=%h exp=%h", x_instr_hold, x_instr); end
        checks++; if (x_start_cycles !== 3) begin failures++; $display("FAIL lat_one_dispatch got=%0d exp=3", x_start_cycles); end
        checks++; if (x_count !== m_count + 16'd1) begin failures++; $display("FAIL lat_count got=%0d exp=%0d", x_count, m_count + 16'd1); end
        m_pc = npc;
        m_count++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            int ml, bl, dl;
            logic [4:0] npc;
            ml = $urandom_range(1, 5); bl = $urandom_range(0, 5); dl = $urandom_range(0, 5);
            npc = 5'($urandom());
            xact(ml, bl, dl, npc, 1'b0, 1'b0);
            checks++; if (x_found !== 1'b1) begin failures++; $display("FAIL rand_req_seen iter=%0d got=%b exp=1", k, x_found); end
            checks++; if (x_addr !== m_pc) begin failures++; $display("FAIL rand_addr iter=%0d got=%0d exp=%0d", k, x_addr, m_pc); end
            checks++; if (x_instr !== expect_word(mem[m_pc], m_pc)) begin failures++; $display("FAIL rand_instr iter=%0d got=%h exp=%h", k, x_instr, expect_word(mem[m_pc], m_pc)); end
            checks++; if (x_start_cycles !== bl + 1) begin failures++; $display("FAIL rand_start_len iter=%0d got=%0d exp=%0d", k, x_start_cycles, bl + 1); end
            checks++; if (x_start_after !== 1'b0) begin failures++; $display("FAIL rand_start_drop iter=%0d got=%b exp=0", k, x_start_after); end
            checks++; if (x_count !== m_count + 16'd1) begin failures++; $display("FAIL rand_count iter=%0d got=%0d exp=%0d", k, x_count, m_count + 16'd1); end
            checks++; if (x_pc !== npc) begin failures++; $display("FAIL rand_pc iter=%0d got=%0d exp=%0d", k, x_pc, npc); end
            checks++; if (x_req_next !== 1'b1 || x_addr_next !== npc) begin failures++; $display("FAIL rand_next_req iter=%0d got=%b/%0d exp=1/%0d", k, x_req_next, x_addr_next, npc); end
            m_pc = npc;
            m_count++;
        end
    endtask

    task automatic test_wrap();
        xact(1, 0, 0, 5'd31, 1'b0, 1'b0);
        m_count++;
        xact(2, 1, 0, 5'd0, 1'b0, 1'b0);
        checks++; if (x_addr !== 5'd31) begin failures++; $display("FAIL wrap_addr31 got=%0d exp=31", x_addr); end
        checks++; if (x_instr[36:32] !== 5'd31) begin failures++; $display("FAIL wrap_stamp31 got=%0d exp=31", x_instr[36:32]); end
        checks++; if (x_pc !== 5'd0 || x_addr_next !== 5'd0) begin failures++; $display("FAIL wrap_to_zero got=%0d/%0d exp=0/0", x_pc, x_addr_next); end
        m_count++;
        m_pc = 5'd0;
    endtask

    task automatic test_halt();
        logic [58:0] saved, prev;
        logic [4:0]  b;
        xact(1, 0, 0, 5'd7, 1'b0, 1'b0);
        m_count++;
        m_pc = 5'd7;
        saved = mem[7];
        mem[7] = rand_word(5'd31);
        prev = instruction;
        fetch_only(2);
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL halt_no_start got=%b exp=0", start); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
        checks++; if (pc !== 5'd7) begin failures++; $display("FAIL halt_pc got=%0d exp=7", pc); end
        checks++; if (fetch_count !== m_count) begin failures++; $display("FAIL halt_count got=%0d exp=%0d", fetch_count, m_count); end
        checks++; if (instruction !== prev) begin failures++; $display("FAIL halt_instr got=%h exp=%h", instruction, prev); end
        tick(); tick(); tick();
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL halt_hold got=%b/%b exp=1/0", halted, imem_req); end
        run = 1'b0;
        tick();
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_release got=%b exp=0", halted); end
        mem[7] = saved;
        b = 5'($urandom_range(0, 6));
        boot_pc = b;
        run = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== b) begin failures++; $display("FAIL halt_to_idle_boot got=%b/%0d exp=1/%0d", imem_req, imem_addr, b); end
        m_pc = b;
    endtask

    task automatic test_run_drop();
        logic [4:0] npc;
        int reqs;
        npc = 5'($urandom_range(8, 30));
        xact(2, 1, 2, npc, 1'b0, 1'b1);
        checks++; if (x_count !== m_count + 16'd1) begin failures++; $display("FAIL drop_count got=%0d exp=%0d", x_count, m_count + 16'd1); end
        checks++; if (x_pc !== npc) begin failures++; $display("FAIL drop_pc got=%0d exp=%0d", x_pc, npc); end
        reqs = int'(x_req_next);
        for (int i = 0; i < 5; i++) begin tick(); reqs += int'(imem_req); end
        checks++; if (reqs !== 0) begin failures++; $display("FAIL drop_no_req got=%0d exp=0", reqs); end
        m_count++;
        boot_pc = npc;
        run = 1'b1;
        tick();
        m_pc = npc;
    endtask

    task automatic test_reset_mid();
        logic [4:0] b;
        fetch_only(1);
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL rstmid_dispatch got=%b exp=1", start); end
        rst = 1'b0;
        tick();
        checks++; if (start !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 5'd0 || pc !== 5'd0) begin failures++; $display("FAIL rstmid_ctrl got=%b/%b/%0d/%0d exp=0/0/0/0", start, imem_req, imem_addr, pc); end
        checks++; if (instruction !== 59'd0 || halted !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL rstmid_data got=%h/%b/%b exp=0/0/0", instruction, halted, error); end
        checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", fetch_count); end
        rst = 1'b1;
        b = 5'($urandom_range(8, 30));
        boot_pc = b;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== b) begin failures++; $display("FAIL rstmid_idle got=%b/%0d exp=1/%0d", imem_req, imem_addr, b); end
        m_pc = b;
        m_count = '0;
    endtask

    task automatic test_watchdog();
        int cnt;
        fetch_only(1);
        cnt = 0;
        while (start && cnt < 30) begin cnt++; tick(); end
        checks++; if (cnt !== 8) begin failures++; $display("FAIL wdog_start_len got=%0d exp=8", cnt); end
        checks++; if (error !== 1'b1 || start !== 1'b0) begin failures++; $display("FAIL wdog_trip got=%b/%b exp=1/0", error, start); end
        run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            decode_busy = 1'($urandom_range(0, 1));
            decode_done = 1'($urandom_range(0, 1));
            tick();
        end
        decode_busy = 1'b0;
        decode_done = 1'b0;
        run = 1'b1;
        tick(); tick();
        checks++; if (error !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL wdog_sticky got=%b/%b exp=1/0", error, imem_req); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run = 1'b0;
        tick();
        checks++; if (error !== 1'b0 || start !== 1'b0) begin failures++; $display("FAIL wdog_clear got=%b/%b exp=0/0", error, start); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = rand_word(5'($urandom_range(0, 30)));
        test_reset();
        test_basic();
        test_latency();
        test_random();
        test_wrap();
        test_halt();
        test_run_drop();
        test_reset_mid();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
